// File: rtl/idmem_arb_pkg.sv
// ============================================================================
// Module : idmem_arb_pkg
// Brief  : Shared encodings for the IDMem arbiter (FSM states, owner IDs).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package idmem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

endpackage : idmem_arb_pkg

`default_nettype wire

// File: rtl/idmem_rr_pick.sv
// ============================================================================
// Module : idmem_rr_pick
// Brief  : Two-way round-robin pick between fetch and data requests.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idmem_rr_pick
    import idmem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_gnt,
    output logic gnt_valid,
    output logic gnt_owner
);

    always_comb begin
        gnt_valid = if_req | dm_req;
        gnt_owner = OWN_IF;
        if (if_req && dm_req) begin
            // On a tie the side that did not go last wins.
            gnt_owner = (last_gnt == OWN_IF) ? OWN_DM : OWN_IF;
        end else if (dm_req) begin
            gnt_owner = OWN_DM;
        end
    end

endmodule : idmem_rr_pick

`default_nettype wire

// File: rtl/idmem_arbiter.sv
// ============================================================================
// Module : idmem_arbiter
// Brief  : Round-robin sequencer sharing one IDMem port between IF and DM.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module idmem_arbiter
    import idmem_arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int AW            = 32,
    parameter int DW            = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wd,
    output logic          dm_ack,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam logic [3:0] c_CNT_LOAD = 4'(ACCESS_CYCLES - 1);
    localparam logic       c_SINGLE   = (ACCESS_CYCLES == 1);

    logic [1:0]    r_state;
    logic [1:0]    w_next_state;
    logic [3:0]    r_cnt;
    logic          r_owner;
    logic          r_last_gnt;
    logic          r_we;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wd;
    logic [DW-1:0] r_if_rdata;
    logic [DW-1:0] r_dm_rdata;
    logic          w_gnt_valid;
    logic          w_gnt_owner;
    logic          w_grant;
    logic          w_gnt_dm_store;

    idmem_rr_pick u_pick (
        .if_req    (if_req),
        .dm_req    (dm_req),
        .last_gnt  (r_last_gnt),
        .gnt_valid (w_gnt_valid),
        .gnt_owner (w_gnt_owner)
    );

    assign w_grant        = (r_state == ST_IDLE) && w_gnt_valid;
    assign w_gnt_dm_store = (w_gnt_owner == OWN_DM) && dm_we;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:   if (w_gnt_valid) w_next_state = ST_ACCESS;
            ST_ACCESS: if (r_cnt == 4'd0) w_next_state = ST_DONE;
            ST_DONE:   w_next_state = ST_IDLE;
            default:   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state == ST_ACCESS) || (r_state == ST_DONE);
        if_ack = (r_state == ST_DONE) && (r_owner == OWN_IF);
        dm_ack = (r_state == ST_DONE) && (r_owner == OWN_DM);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt      <= 4'd0;
            r_owner    <= OWN_IF;
            r_last_gnt <= OWN_IF;
            r_we       <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_wd   <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
        end else if (w_grant) begin
            r_owner    <= w_gnt_owner;
            r_last_gnt <= w_gnt_owner;
            r_we       <= w_gnt_dm_store;
            r_mem_addr <= (w_gnt_owner == OWN_DM) ? dm_addr : if_addr;
            r_mem_wd   <= (w_gnt_owner == OWN_DM) ? dm_wd : '0;
            // Single-cycle windows write in the very first ACCESS cycle.
            r_mem_we   <= w_gnt_dm_store && c_SINGLE;
            r_cnt      <= c_CNT_LOAD;
        end else if (r_state == ST_ACCESS) begin
            if (r_cnt != 4'd0) begin
                r_cnt    <= r_cnt - 4'd1;
                r_mem_we <= r_we && (r_cnt == 4'd1);
            end else begin
                r_mem_we <= 1'b0;
                if (!r_we) begin
                    if (r_owner == OWN_DM) begin
                        r_dm_rdata <= mem_dout;
                    end else begin
                        r_if_rdata <= mem_dout;
                    end
                end
            end
        end
    end

    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_wd   = r_mem_wd;
    assign if_rdata = r_if_rdata;
    assign dm_rdata = r_dm_rdata;

endmodule : idmem_arbiter

`default_nettype wire

// File: tb/tb_idmem_arbiter.sv
// ============================================================================
// Module : tb_idmem_arbiter
// Brief  : Bench for idmem_arbiter: two instances (1- and 3-cycle windows).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_idmem_arbiter;

    logic        clk = 1'b0;
    logic [1:0]  nRST;
    logic [1:0]  if_req, if_ack, dm_req, dm_we, dm_ack, mem_we, busy;
    logic [31:0] if_addr [2];
    logic [31:0] if_rdata[2];
    logic [31:0] dm_addr [2];
    logic [31:0] dm_wd   [2];
    logic [31:0] dm_rdata[2];
    logic [31:0] mem_addr[2];
    logic [31:0] mem_wd  [2];
    logic [31:0] mem_dout[2];
    logic [31:0] mem     [2][16];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign mem_dout[0] = mem[0][mem_addr[0][3:0]];
    assign mem_dout[1] = mem[1][mem_addr[1][3:0]];

    idmem_arbiter #(.ACCESS_CYCLES(1), .AW(32), .DW(32)) u_dut0 (
        .CLK(clk), .nRST(nRST[0]),
        .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
        .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wd(dm_wd[0]),
        .dm_ack(dm_ack[0]), .dm_rdata(dm_rdata[0]),
        .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wd(mem_wd[0]),
        .mem_dout(mem_dout[0]), .busy(busy[0])
    );

    idmem_arbiter #(.ACCESS_CYCLES(3), .AW(32), .DW(32)) u_dut1 (
        .CLK(clk), .nRST(nRST[1]),
        .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
        .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wd(dm_wd[1]),
        .dm_ack(dm_ack[1]), .dm_rdata(dm_rdata[1]),
        .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wd(mem_wd[1]),
        .mem_dout(mem_dout[1]), .busy(busy[1])
    );

    function automatic void chk(input string nm, input int i,
                                input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] got %h expected %h", nm, i, got, exp);
        end
    endfunction

    // IDMem: combinational read, write on the rising edge.
    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++)
                mem[i][k] = 32'h100 + k;
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++)
                if (mem_we[i] === 1'b1) mem[i][mem_addr[i][3:0]] <= mem_wd[i];
        end
    end

    // Transaction-level model: an access occupies cycles 1..AC, ack in cycle AC+1.
    int          acv [2] = '{1, 3};
    bit          act [2];
    int          t   [2];
    bit          own [2];
    bit          we_m[2];
    bit          last[2];
    logic [31:0] a_m [2];
    logic [31:0] wd_m[2];
    logic [31:0] rif [2];
    logic [31:0] rdm [2];
    logic [31:0] refm[2][16];

    initial begin
        for (int i = 0; i < 2; i++)
            for (int k = 0; k < 16; k++)
                refm[i][k] = 32'h100 + k;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (nRST[i] !== 1'b1) begin
                    act[i] = 0; t[i] = 0; own[i] = 0; we_m[i] = 0; last[i] = 0;
                    a_m[i] = '0; wd_m[i] = '0; rif[i] = '0; rdm[i] = '0;
                    chk("rst_mem_addr", i, mem_addr[i], 32'h0);
                end
                chk("busy",     i, 32'(busy[i]),   32'(act[i]));
                chk("mem_we",   i, 32'(mem_we[i]), 32'(act[i] && t[i] == acv[i] && we_m[i]));
                chk("if_ack",   i, 32'(if_ack[i]), 32'(act[i] && t[i] == acv[i] + 1 && !own[i]));
                chk("dm_ack",   i, 32'(dm_ack[i]), 32'(act[i] && t[i] == acv[i] + 1 && own[i]));
                chk("if_rdata", i, if_rdata[i], rif[i]);
                chk("dm_rdata", i, dm_rdata[i], rdm[i]);
                if (act[i] && t[i] <= acv[i]) begin
                    chk("mem_addr", i, mem_addr[i], a_m[i]);
                    if (we_m[i]) chk("mem_wd", i, mem_wd[i], wd_m[i]);
                end
                if (nRST[i] === 1'b1) begin
                    if (!act[i]) begin
                        if (if_req[i] || dm_req[i]) begin
                            if (if_req[i] && dm_req[i]) own[i] = (last[i] == 1'b0);
                            else                        own[i] = dm_req[i];
                            last[i] = own[i];
                            a_m[i]  = own[i] ? dm_addr[i] : if_addr[i];
                            we_m[i] = own[i] && dm_we[i];
                            wd_m[i] = dm_wd[i];
                            act[i]  = 1;
                            t[i]    = 1;
                        end
                    end else if (t[i] < acv[i]) begin
                        t[i]++;
                    end else if (t[i] == acv[i]) begin
                        if (we_m[i])     refm[i][a_m[i][3:0]] = wd_m[i];
                        else if (own[i]) rdm[i] = refm[i][a_m[i][3:0]];
                        else             rif[i] = refm[i][a_m[i][3:0]];
                        t[i]++;
                    end else begin
                        act[i] = 0;
                    end
                end
            end
        end
    end

    task automatic do_access(input int i, input bit dm, input bit we_,
                             input logic [31:0] ad, input logic [31:0] d,
                             output int lat, output int wc);
        if (dm) begin
            dm_req[i] = 1'b1; dm_we[i] = we_; dm_addr[i] = ad; dm_wd[i] = d;
        end else begin
            if_req[i] = 1'b1; if_addr[i] = ad;
        end
        lat = 0;
        wc  = 0;
        forever begin
            @(posedge clk); #2;
            lat++;
            wc += int'(mem_we[i]);
            if (dm ? dm_ack[i] : if_ack[i]) break;
            if (lat > 40) begin
                n_vec++; n_err++;
                $display("FAIL ack_timeout[%0d] got no ack expected ack within 40 cycles", i);
                break;
            end
        end
        if_req[i] = 1'b0;
        dm_req[i] = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input int i);
        if_req[i] = 1'b0;
        dm_req[i] = 1'b0;
        nRST[i]   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nRST[i] = 1'b1;
    endtask

    initial begin
        int lat, wc, nack;
        int order[4];
        nRST = 2'b00; if_req = '0; dm_req = '0; dm_we = '0;
        for (int i = 0; i < 2; i++) begin
            if_addr[i] = '0; dm_addr[i] = '0; dm_wd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #2;
        nRST = 2'b11;

        // Idle after reset
        repeat (4) @(posedge clk);
        #2;
        chk("t1_busy",   0, 32'(busy[0]),   32'h0);
        chk("t1_mem_we", 0, 32'(mem_we[0]), 32'h0);
        chk("t1_acks",   0, 32'({if_ack[0], dm_ack[0]}), 32'h0);

        // Single fetch
        do_access(0, 1'b0, 1'b0, 32'd3, 32'h0, lat, wc);
        chk("t2_latency", 0, 32'(lat), 32'd2);
        repeat (2) @(posedge clk);
        #2;
        chk("t2_if_rdata", 0, if_rdata[0], 32'h103);

        // Store then load
        do_access(0, 1'b1, 1'b1, 32'd5, 32'hDEADBEEF, lat, wc);
        chk("t3_we_cycles", 0, 32'(wc), 32'd1);
        chk("t3_dm_rdata_kept", 0, dm_rdata[0], 32'h0);
        do_access(0, 1'b1, 1'b0, 32'd5, 32'h0, lat, wc);
        chk("t3_load", 0, dm_rdata[0], 32'hDEADBEEF);

        // Contention from reset: DM first, then alternation
        do_reset(0);
        for (int k = 0; k < 4; k++) order[k] = -1;
        if_addr[0] = 32'd1; dm_addr[0] = 32'd2; dm_we[0] = 1'b0;
        if_req[0] = 1'b1; dm_req[0] = 1'b1;
        nack = 0;
        for (int c = 0; c < 60 && nack < 4; c++) begin
            @(posedge clk); #2;
            if (dm_ack[0]) begin order[nack] = 1; nack++; dm_req[0] = 1'b0; end
            else if (!dm_req[0] && nack < 4) dm_req[0] = 1'b1;
            if (if_ack[0]) begin order[nack] = 0; nack++; if_req[0] = 1'b0; end
            else if (!if_req[0] && nack < 4) if_req[0] = 1'b1;
        end
        if_req[0] = 1'b0; dm_req[0] = 1'b0;
        chk("t4_nack",   0, 32'(nack),     32'd4);
        chk("t4_order0", 0, 32'(order[0]), 32'd1);
        chk("t4_order1", 0, 32'(order[1]), 32'd0);
        chk("t4_order2", 0, 32'(order[2]), 32'd1);
        chk("t4_order3", 0, 32'(order[3]), 32'd0);
        repeat (4) @(posedge clk);
        #2;
        chk("t4_dm_rdata", 0, dm_rdata[0], 32'h102);
        chk("t4_if_rdata", 0, if_rdata[0], 32'h101);

        // Three-cycle window store
        do_access(1, 1'b1, 1'b1, 32'd7, 32'hCAFE0007, lat, wc);
        chk("t5_latency",   1, 32'(lat), 32'd4);
        chk("t5_we_cycles", 1, 32'(wc),  32'd1);
        chk("t5_mem7",      1, mem[1][7], 32'hCAFE0007);

        // Reset lands in the write cycle: write must not happen
        dm_req[1] = 1'b1; dm_we[1] = 1'b1; dm_addr[1] = 32'd7; dm_wd[1] = 32'h0BADF00D;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_we_before", 1, 32'(mem_we[1]), 32'h1);
        #1 nRST[1] = 1'b0;
        #1;
        chk("t6_we_async",   1, 32'(mem_we[1]), 32'h0);
        chk("t6_busy_async", 1, 32'(busy[1]),   32'h0);
        chk("t6_no_ack",     1, 32'(dm_ack[1]), 32'h0);
        dm_req[1] = 1'b0;
        @(posedge clk); #2;
        nRST[1] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("t6_mem7_kept", 1, mem[1][7], 32'hCAFE0007);

        // Random traffic on both instances
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #2;
            for (int i = 0; i < 2; i++) begin
                if (if_req[i] && if_ack[i]) begin
                    if_req[i] = 1'b0;
                end else if (!if_req[i] && $urandom_range(0, 2) == 0) begin
                    if_req[i]  = 1'b1;
                    if_addr[i] = $urandom;
                end
                if (dm_req[i] && dm_ack[i]) begin
                    dm_req[i] = 1'b0;
                end else if (!dm_req[i] && $urandom_range(0, 2) == 0) begin
                    dm_req[i]  = 1'b1;
                    dm_we[i]   = 1'($urandom_range(0, 1));
                    dm_addr[i] = $urandom;
                    dm_wd[i]   = $urandom;
                end
            end
        end
        if_req = '0;
        dm_req = '0;
        repeat (8) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_idmem_arbiter

`default_nettype wire

// File: doc/idmem_arbiter.md
Name: idmem_arbiter

Overview:
- Sequences the single-ported unified instruction/data memory (IDMem) of the multicycle processor.
- Shares IDMem between two requesters: instruction fetch (IF) and data load/store (DM).
- Round-robin arbitration, fixed-length access window, one-cycle ack pulse.
- Registered read data per requester; all memory-side outputs registered.

Parameters:
ACCESS_CYCLES, 1, cycles mem_addr is held per access (1..15); IDMem read is combinational, write occurs on CLK edge.
AW, 32, address width (word address, +1 per word).
DW, 32, data width.

Ports:
CLK  in  1  clock, rising edge.
nRST  in  1  reset, asynchronous, active-low.
if_req  in  1  fetch request, level, held until if_ack.
if_addr  in  AW  fetch address, stable while if_req high.
if_ack  out  1  one-cycle completion pulse.
if_rdata  out  DW  fetched word, valid from if_ack, held until next IF completion.
dm_req  in  1  data request, level, held until dm_ack.
dm_we  in  1  1=store, 0=load; stable while dm_req high.
dm_addr  in  AW  data address.
dm_wd  in  DW  store data.
dm_ack  out  1  one-cycle completion pulse.
dm_rdata  out  DW  load data, valid from dm_ack, updated only by loads.
mem_we  out  1  to IDMem We.
mem_addr  out  AW  to IDMem addr.
mem_wd  out  DW  to IDMem Wd.
mem_dout  in  DW  from IDMem dout.
busy  out  1  high in ACCESS and DONE.

Behaviour:
- Reset (nRST low, async): state IDLE, cnt=0, last_gnt=IF; all outputs 0, including rdata regs. Mid-access reset aborts: mem_we drops immediately, no ack issued.
- States: IDLE, ACCESS, DONE.
- IDLE: requests sampled at each edge. None: stay. One: grant it. Both: grant the one not equal to last_gnt (after reset, DM wins the first tie). On grant: latch owner, addr, we (IF: we=0), wd into mem_* regs; last_gnt<=owner; cnt<=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS: mem_addr/mem_wd held constant. mem_we=1 only in the final ACCESS cycle (cnt==0) for stores, so exactly one write edge. cnt>0: decrement. cnt==0: on the edge, capture mem_dout into owner's rdata (loads/fetches only), mem_we<=0, go to DONE.
- DONE: owner's ack=1 for exactly this cycle; mem_we=0. Next state IDLE unconditionally.
- Requester must deassert req on the edge ending its ack cycle; req still high in IDLE is a new request.
- Latency: req seen at edge E, ack in cycle E+ACCESS_CYCLES+1. Peak throughput is one access per ACCESS_CYCLES+2 cycles.
- A request arriving during ACCESS/DONE waits; the other requester is never starved (alternation on contention).
- No address checking; full AW bits pass through unmodified.
- Unused ack is 0; both acks are never high together.

Decomposition:
- Package idmem_arb_pkg holds: state encodings (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2); owner IDs (OWN_IF=1'b0, OWN_DM=1'b1).
- One small combinational sub-module, idmem_rr_pick: inputs if_req, dm_req, last_gnt; outputs gnt_valid, gnt_owner.
- Everything else stays in the top module.

Test Plan:
1. Reset behaviour: ACCESS_CYCLES=1, IDMem preloaded with word k = 32'h100+k. Reset released, no requests -> busy=0, acks=0, mem_we=0 indefinitely.
2. Single fetch: if_req with if_addr=3 -> mem_addr=3 for 1 cycle; if_ack 2 cycles after req is sampled; if_rdata=32'h103, held after if_req drops.
3. Store then load: store dm_addr=5, dm_wd=32'hDEADBEEF -> exactly one mem_we cycle, dm_rdata unchanged. Then load addr 5 -> dm_rdata=32'hDEADBEEF.
4. Contention from reset: if_req(addr 1) and dm_req(load addr 2) in the same cycle -> DM served first (dm_rdata=32'h102), then IF (if_rdata=32'h101). Both held continuously -> grants alternate DM, IF, DM, IF.
5. ACCESS_CYCLES=3: store addr 7 -> mem_addr stable for 3 cycles, mem_we high only in the 3rd, ack 4 cycles after grant.
6. Reset mid-store: assert nRST low during ACCESS -> mem_we falls asynchronously, no dm_ack. Memory word 7 retains its old value when reset hits before the write cycle.
